// File: rtl/video_pkg.sv
// Shared video stream definitions used by the conformer and the formatter.
package video_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PASS     = 2'd1,
        PAD      = 2'd2,
        DROP     = 2'd3
    } conform_state_t;

    localparam int          VID_MAXWIDTH  = 1280;
    localparam logic [31:0] VID_PAD_PIXEL = 32'h0000_0000;

    function automatic logic [11:0] clamp_dim(
        input logic [11:0] v,
        input logic [11:0] hi
    );
        if (v == 12'd0) return 12'd1;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream register slice carrying 32-bit data, tlast and tuser.
module axis_reg_slice (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_user,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_user,
    input  logic        out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_last <= in_last;
                out_user <= in_user;
            end
        end
    end

endmodule

// File: rtl/video_stream_conformer.sv
// Forces a VDMA stream into exact cfg_width x cfg_height frames by padding and dropping.
// Define VIDEO_CONFORM_STATS_EN to add short/long/early-SOF event counters.
module video_stream_conformer
    import video_pkg::*;
#(
    parameter int          MAXWIDTH  = VID_MAXWIDTH,
    parameter logic [31:0] PAD_PIXEL = VID_PAD_PIXEL
) (
    input  logic        m_axis_vid_aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    output logic        m_axis_vid_tlast,
    output logic        m_axis_vid_tuser,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_height,
    output logic        frame_active
`ifdef VIDEO_CONFORM_STATS_EN
    ,
    output logic [15:0] stat_short_lines,
    output logic [15:0] stat_long_lines,
    output logic [15:0] stat_early_sof
`endif
);

    localparam logic [11:0] WMAX = 12'(MAXWIDTH);
    localparam logic [11:0] HMAX = 12'd4095;

    conform_state_t state;
    logic [11:0] x, y, w, h;
    logic [11:0] bx, by, bw, bh;
    logic        fin;
    logic        slice_ready;
    logic        take, sof, fwd, pad_go, push;
    logic        el, ef;
    logic [31:0] push_data;

    always_comb begin
        s_axis_tready = 1'b0;
        unique case (state)
            WAIT_SOF: s_axis_tready = 1'b1;
            PASS:     s_axis_tready = slice_ready && !fin;
            PAD:      s_axis_tready = 1'b0;
            DROP:     s_axis_tready = slice_ready || !s_axis_tuser;
            default:  s_axis_tready = 1'b0;
        endcase
        if (!aresetn) s_axis_tready = 1'b0;
    end

    assign take   = s_axis_tvalid && s_axis_tready;
    assign sof    = take && s_axis_tuser;
    assign fwd    = take && (sof || state == PASS);
    assign pad_go = aresetn && state == PAD && slice_ready;
    assign push   = fwd || pad_go;

    // An SOF beat is placed at (0,0) of a frame sized from the live config.
    assign bx = sof ? 12'd0 : x;
    assign by = sof ? 12'd0 : y;
    assign bw = sof ? clamp_dim(cfg_width, WMAX) : w;
    assign bh = sof ? clamp_dim(cfg_height, HMAX) : h;
    assign el = (bx == bw - 12'd1);
    assign ef = el && (by == bh - 12'd1);

    assign push_data    = pad_go ? PAD_PIXEL : s_axis_tdata;
    assign frame_active = aresetn && (state != WAIT_SOF);

    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            state <= WAIT_SOF;
            x     <= '0;
            y     <= '0;
            w     <= 12'd1;
            h     <= 12'd1;
            fin   <= 1'b0;
        end else if (fin) begin
            if (m_axis_vid_tvalid && m_axis_vid_tready) begin
                state <= WAIT_SOF;
                x     <= '0;
                y     <= '0;
                fin   <= 1'b0;
            end
        end else if (push) begin
            if (sof) begin
                w <= bw;
                h <= bh;
            end
            if (ef) begin
                x     <= '0;
                y     <= '0;
                fin   <= 1'b1;
                state <= PASS;
            end else if (el) begin
                x     <= '0;
                y     <= by + 12'd1;
                state <= (fwd && !s_axis_tlast) ? DROP : PASS;
            end else begin
                x     <= bx + 12'd1;
                y     <= by;
                state <= (pad_go || s_axis_tlast) ? PAD : PASS;
            end
        end else if (take && state == DROP && s_axis_tlast) begin
            state <= PASS;
        end
    end

    axis_reg_slice u_slice (
        .aclk      (m_axis_vid_aclk),
        .aresetn   (aresetn),
        .in_data   (push_data),
        .in_valid  (push),
        .in_last   (el),
        .in_user   (fwd && sof),
        .in_ready  (slice_ready),
        .out_data  (m_axis_vid_tdata),
        .out_valid (m_axis_vid_tvalid),
        .out_last  (m_axis_vid_tlast),
        .out_user  (m_axis_vid_tuser),
        .out_ready (m_axis_vid_tready)
    );

`ifdef VIDEO_CONFORM_STATS_EN
    logic short_ev, long_ev, early_ev;

    assign short_ev = fwd && s_axis_tlast && !el;
    assign long_ev  = fwd && !s_axis_tlast && el;
    assign early_ev = sof && state != WAIT_SOF && (x != 12'd0 || y != 12'd0);

    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            stat_short_lines <= '0;
            stat_long_lines  <= '0;
            stat_early_sof   <= '0;
        end else begin
            if (short_ev && stat_short_lines != 16'hFFFF)
                stat_short_lines <= stat_short_lines + 16'd1;
            if (long_ev && stat_long_lines != 16'hFFFF)
                stat_long_lines <= stat_long_lines + 16'd1;
            if (early_ev && stat_early_sof != 16'hFFFF)
                stat_early_sof <= stat_early_sof + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_stream_conformer.sv
// Directed self-checking bench for video_stream_conformer.
module tb_video_stream_conformer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic [11:0] cfg_width, cfg_height;
    logic        frame_active;
`ifdef VIDEO_CONFORM_STATS_EN
    logic [15:0] st_short, st_long, st_early;
`endif

    always #5 clk = ~clk;

    video_stream_conformer dut (
        .m_axis_vid_aclk   (clk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .s_axis_tlast      (s_tlast),
        .s_axis_tuser      (s_tuser),
        .m_axis_vid_tdata  (m_tdata),
        .m_axis_vid_tvalid (m_tvalid),
        .m_axis_vid_tready (m_tready),
        .m_axis_vid_tlast  (m_tlast),
        .m_axis_vid_tuser  (m_tuser),
        .cfg_width         (cfg_width),
        .cfg_height        (cfg_height),
        .frame_active      (frame_active)
`ifdef VIDEO_CONFORM_STATS_EN
        ,
        .stat_short_lines  (st_short),
        .stat_long_lines   (st_long),
        .stat_early_sof    (st_early)
`endif
    );

    int passed = 0;
    int total  = 0;
    int stall_err = 0;
    logic [33:0] obs[$];
    logic [33:0] exp[$];
    logic        prev_stall = 1'b0;
    logic [33:0] held = '0;

    // Output monitor: records accepted beats and flags changes while stalled.
    always @(negedge clk) begin
        if (aresetn && prev_stall && {m_tuser, m_tlast, m_tdata} !== held)
            stall_err <= stall_err + 1;
        prev_stall <= aresetn && m_tvalid && !m_tready;
        held <= {m_tuser, m_tlast, m_tdata};
        if (aresetn && m_tvalid && m_tready)
            obs.push_back({m_tuser, m_tlast, m_tdata});
    end

    function automatic logic [33:0] bt(input logic u, input logic l,
                                       input logic [31:0] d);
        return {u, l, d};
    endfunction

    task automatic drive(input logic [31:0] d, input logic u, input logic l,
                         output int waits);
        waits = 0;
        s_tdata = d;
        s_tuser = u;
        s_tlast = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && waits < 500) begin
            waits++;
            @(negedge clk);
        end
        if (!s_tready) begin
            total++;
            $display("FAIL drive_timeout: s_tready=%0b after %0d cycles, required 1",
                     s_tready, waits);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic u, input logic l);
        int w;
        drive(d, u, l, w);
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        m_tready = 1'b1;
        obs.delete();
        exp.delete();
        stall_err = 0;
    endtask

    task automatic wait_out(input int n);
        int c;
        c = 0;
        while (obs.size() < n && c < 3000) begin
            c++;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 35'd0)
            $display("FAIL reset_m: got %h, required 0",
                     {m_tvalid, m_tlast, m_tuser, m_tdata});
        else passed++;
        total++;
        if (s_tready !== 1'b0)
            $display("FAIL reset_s_tready: got %b, required 0", s_tready);
        else passed++;
        total++;
        if (frame_active !== 1'b0)
            $display("FAIL reset_active: got %b, required 0", frame_active);
        else passed++;
`ifdef VIDEO_CONFORM_STATS_EN
        total++;
        if ({st_short, st_long, st_early} !== 48'd0)
            $display("FAIL reset_stats: got %h, required 0",
                     {st_short, st_long, st_early});
        else passed++;
`endif
        @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic test_clean();
        apply_reset();
        cfg_width = 12'd4;
        cfg_height = 12'd2;
        send(32'hDEAD_0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp.push_back(bt(i == 0, i == 3 || i == 7, 32'hA000_0000 + 32'(i)));
            send(32'hA000_0000 + 32'(i), i == 0, i == 3 || i == 7);
        end
        wait_out(exp.size());
        total++;
        if (obs.size() != exp.size())
            $display("FAIL clean_count: got %0d, required %0d", obs.size(), exp.size());
        else passed++;
        foreach (exp[i]) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp[i])
                $display("FAIL clean_beat%0d: got %h, required %h", i,
                         (i < obs.size()) ? obs[i] : 34'h0, exp[i]);
            else passed++;
        end
        total++;
        if (frame_active !== 1'b0)
            $display("FAIL clean_active: got %b, required 0", frame_active);
        else passed++;
    endtask

    task automatic test_short();
        int w;
        apply_reset();
        cfg_width = 12'd4;
        cfg_height = 12'd2;
        exp.push_back(bt(1, 0, 32'hB000_0000));
        exp.push_back(bt(0, 0, 32'hB000_0001));
        exp.push_back(bt(0, 0, 32'h0));
        exp.push_back(bt(0, 1, 32'h0));
        send(32'hB000_0000, 1'b1, 1'b0);
        send(32'hB000_0001, 1'b0, 1'b1);
        exp.push_back(bt(0, 0, 32'hB100_0000));
        drive(32'hB100_0000, 1'b0, 1'b0, w);
        total++;
        if (w != 2)
            $display("FAIL short_stall: got %0d cycles, required 2", w);
        else passed++;
        for (int i = 1; i < 4; i++) begin
            exp.push_back(bt(0, i == 3, 32'hB100_0000 + 32'(i)));
            send(32'hB100_0000 + 32'(i), 1'b0, i == 3);
        end
        wait_out(exp.size());
        total++;
        if (obs.size() != exp.size())
            $display("FAIL short_count: got %0d, required %0d", obs.size(), exp.size());
        else passed++;
        foreach (exp[i]) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp[i])
                $display("FAIL short_beat%0d: got %h, required %h", i,
                         (i < obs.size()) ? obs[i] : 34'h0, exp[i]);
            else passed++;
        end
`ifdef VIDEO_CONFORM_STATS_EN
        total++;
        if (st_short !== 16'd1)
            $display("FAIL short_stat: got %0d, required 1", st_short);
        else passed++;
`endif
    endtask

    task automatic test_long();
        apply_reset();
        cfg_width = 12'd4;
        cfg_height = 12'd2;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp.push_back(bt(i == 0, i == 3, 32'hC000_0000 + 32'(i)));
            send(32'hC000_0000 + 32'(i), i == 0, i == 5);
        end
        for (int i = 0; i < 4; i++) begin
            exp.push_back(bt(0, i == 3, 32'hC100_0000 + 32'(i)));
            send(32'hC100_0000 + 32'(i), 1'b0, i == 3);
        end
        wait_out(exp.size());
        total++;
        if (obs.size() != exp.size())
            $display("FAIL long_count: got %0d, required %0d", obs.size(), exp.size());
        else passed++;
        foreach (exp[i]) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp[i])
                $display("FAIL long_beat%0d: got %h, required %h", i,
                         (i < obs.size()) ? obs[i] : 34'h0, exp[i]);
            else passed++;
        end
`ifdef VIDEO_CONFORM_STATS_EN
        total++;
        if (st_long !== 16'd1)
            $display("FAIL long_stat: got %0d, required 1", st_long);
        else passed++;
`endif
    endtask

    task automatic test_early_sof();
        apply_reset();
        cfg_width = 12'd4;
        cfg_height = 12'd2;
        for (int i = 0; i < 4; i++) begin
            exp.push_back(bt(i == 0, i == 3, 32'hD000_0000 + 32'(i)));
            send(32'hD000_0000 + 32'(i), i == 0, i == 3);
        end
        for (int i = 0; i < 2; i++) begin
            exp.push_back(bt(0, 0, 32'hD100_0000 + 32'(i)));
            send(32'hD100_0000 + 32'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            exp.push_back(bt(i == 0, i == 3 || i == 7, 32'hD200_0000 + 32'(i)));
            send(32'hD200_0000 + 32'(i), i == 0, i == 3 || i == 7);
        end
        wait_out(exp.size());
        total++;
        if (obs.size() != exp.size())
            $display("FAIL early_count: got %0d, required %0d", obs.size(), exp.size());
        else passed++;
        foreach (exp[i]) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp[i])
                $display("FAIL early_beat%0d: got %h, required %h", i,
                         (i < obs.size()) ? obs[i] : 34'h0, exp[i]);
            else passed++;
        end
`ifdef VIDEO_CONFORM_STATS_EN
        total++;
        if ({st_early, st_short} !== {16'd1, 16'd0})
            $display("FAIL early_stat: got early=%0d short=%0d, required 1 and 0",
                     st_early, st_short);
        else passed++;
`endif
    endtask

    task automatic test_boundary();
        apply_reset();
        cfg_width = 12'd0;
        cfg_height = 12'd1;
        exp.push_back(bt(1, 1, 32'hE000_0000));
        send(32'hE000_0000, 1'b1, 1'b1);
        cfg_width = 12'd4;
        exp.push_back(bt(1, 0, 32'hE100_0000));
        exp.push_back(bt(0, 0, 32'h0));
        exp.push_back(bt(0, 0, 32'h0));
        exp.push_back(bt(0, 1, 32'h0));
        send(32'hE100_0000, 1'b1, 1'b1);
        wait_out(exp.size());
        total++;
        if (obs.size() != exp.size())
            $display("FAIL bound_count: got %0d, required %0d", obs.size(), exp.size());
        else passed++;
        foreach (exp[i]) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp[i])
                $display("FAIL bound_beat%0d: got %h, required %h", i,
                         (i < obs.size()) ? obs[i] : 34'h0, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back_stall();
        bit run;
        apply_reset();
        cfg_width = 12'd16;
        cfg_height = 12'd4;
        run = 1'b1;
        fork
            begin
                for (int f = 0; f < 3; f++)
                    for (int yy = 0; yy < 4; yy++)
                        for (int xx = 0; xx < 16; xx++) begin
                            logic [31:0] d;
                            d = 32'hF000_0000 + 32'(f * 256 + yy * 16 + xx);
                            exp.push_back(bt(xx == 0 && yy == 0, xx == 15, d));
                            send(d, xx == 0 && yy == 0, xx == 15);
                        end
                run = 1'b0;
            end
            begin
                while (run) begin
                    @(posedge clk);
                    #1;
                    m_tready = ($urandom_range(0, 99) >= 30);
                end
            end
        join
        m_tready = 1'b1;
        wait_out(exp.size());
        total++;
        if (obs.size() != exp.size())
            $display("FAIL stall_count: got %0d, required %0d", obs.size(), exp.size());
        else passed++;
        foreach (exp[i]) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp[i])
                $display("FAIL stall_beat%0d: got %h, required %h", i,
                         (i < obs.size()) ? obs[i] : 34'h0, exp[i]);
            else passed++;
        end
        total++;
        if (stall_err != 0)
            $display("FAIL stall_hold: got %0d changes while stalled, required 0",
                     stall_err);
        else passed++;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        cfg_width = 12'd4;
        cfg_height = 12'd2;
        send(32'h9000_0000, 1'b1, 1'b0);
        send(32'h9000_0001, 1'b0, 1'b0);
        m_tready = 1'b0;
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 35'd0)
            $display("FAIL mreset_m: got %h, required 0",
                     {m_tvalid, m_tlast, m_tuser, m_tdata});
        else passed++;
        total++;
        if ({frame_active, s_tready} !== 2'b01)
            $display("FAIL mreset_ctl: got active,ready=%b, required 01",
                     {frame_active, s_tready});
        else passed++;
        obs.delete();
        m_tready = 1'b1;
        send(32'h9000_0002, 1'b0, 1'b0);
        send(32'h9000_0003, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            exp.push_back(bt(i == 0, i == 3 || i == 7, 32'h9100_0000 + 32'(i)));
            send(32'h9100_0000 + 32'(i), i == 0, i == 3 || i == 7);
        end
        wait_out(exp.size());
        total++;
        if (obs.size() != exp.size())
            $display("FAIL mreset_count: got %0d, required %0d", obs.size(), exp.size());
        else passed++;
        foreach (exp[i]) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp[i])
                $display("FAIL mreset_beat%0d: got %h, required %h", i,
                         (i < obs.size()) ? obs[i] : 34'h0, exp[i]);
            else passed++;
        end
    endtask

    initial begin
        aresetn = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        m_tready = 1'b1;
        cfg_width = 12'd4;
        cfg_height = 12'd2;
        test_reset();
        test_clean();
        test_short();
        test_long();
        test_early_sof();
        test_boundary();
        test_back_to_back_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/video_stream_conformer.md
VIDEO_STREAM_CONFORMER -- requirements
Module: video_stream_conformer

Interface
REQ-001 SHALL have parameter MAXWIDTH, default 1280, the largest accepted line length in 32-bit beats.
REQ-002 SHALL have parameter PAD_PIXEL, default 32'h00000000, the data value driven on padded beats.
REQ-003 SHALL have port m_axis_vid_aclk, input, 1 bit: the clock for all logic.
REQ-004 SHALL have port aresetn, input, 1 bit: synchronous, active-low reset; the clock is m_axis_vid_aclk.
REQ-005 SHALL have ports s_axis_tdata in 32, s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tlast in 1, s_axis_tuser in 1: the VDMA-side input stream.
REQ-006 SHALL have ports m_axis_vid_tdata out 32, m_axis_vid_tvalid out 1, m_axis_vid_tready in 1, m_axis_vid_tlast out 1, m_axis_vid_tuser out 1: the stream to the formatter.
REQ-007 SHALL have ports cfg_width in 12 and cfg_height in 12: the expected frame geometry in beats and lines.
REQ-008 SHALL have port frame_active, output, 1 bit: high while a frame is being emitted.

Function
REQ-009 SHALL emit exactly cfg_height lines of exactly cfg_width beats per frame.
- tuser SHALL be set on beat (0,0) only.
- tlast SHALL be set on beat x = width-1 only.
REQ-010 SHALL latch cfg_width and cfg_height on accepting the SOF beat; both SHALL be clamped to the range 1..MAXWIDTH and 1..4095.
REQ-011 SHALL implement the states WAIT_SOF, PASS, PAD and DROP.
REQ-012 In WAIT_SOF, SHALL hold s_axis_tready=1, discard beats with tuser=0, and on a tuser beat forward it as (0,0) and enter PASS.
REQ-013 In PASS, SHALL drive s_axis_tready = !m_tvalid || m_tready; each accepted beat SHALL appear on the output one cycle later (one registered slice).
REQ-014 On a short line (input tlast with x < width-1), SHALL forward that beat with tlast=0 and enter PAD.
- In PAD, s_axis_tready SHALL be 0.
- PAD SHALL emit PAD_PIXEL beats until x = width-1, carrying tlast, then return to PASS.
REQ-015 On a long line (x = width-1 without input tlast), SHALL emit that beat with tlast=1 and enter DROP.
- In DROP, s_axis_tready SHALL be 1 and beats SHALL be discarded up to and including the input tlast beat, then return to PASS.
REQ-016 After the tlast of line height-1 is accepted downstream, SHALL clear the x/y counters and enter WAIT_SOF.
REQ-017 On an input tuser beat in PASS or DROP with (x,y)≠(0,0) (early SOF), SHALL abandon the current frame and treat that beat as the new (0,0) without emitting padding.
REQ-018 An input beat carrying both tuser and tlast SHALL start a 1-beat line and then PAD when width > 1.
REQ-019 SHALL hold output data, tlast and tuser stable while m_tvalid=1 and m_tready=0.
REQ-020 SHALL drive frame_active=1 from acceptance of the SOF beat through acceptance of the final tlast beat.

Reset
REQ-021 While aresetn=0, SHALL drive m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, s_tready=0, frame_active=0, x=y=0 and state WAIT_SOF.
REQ-022 A reset mid-frame SHALL drop any pending output beat; the first frame after reset SHALL begin only at the next input tuser.

Configuration
REQ-023 With VIDEO_CONFORM_STATS_EN defined, SHALL add three 16-bit saturating output counters: stat_short_lines, stat_long_lines and stat_early_sof.
- Each counter SHALL increment once per event.
- The counters SHALL clear on reset.
REQ-024 Without VIDEO_CONFORM_STATS_EN, those ports and counters SHALL be absent and the behaviour SHALL otherwise be identical.

Structure
REQ-025 The state enum, the MAXWIDTH default and the PAD_PIXEL default SHALL live in the shared package video_pkg, which the formatter also uses.
REQ-026 The output register slice SHALL be a sub-module, axis_reg_slice (32-bit data plus tlast and tuser), instantiated once.

Verification
REQ-027 Width 4, height 2, clean 4-beat lines, tready=1 -> 8 output beats; tuser on beat 0; tlast on beats 3 and 7; back in WAIT_SOF.
REQ-028 Width 4, input line of 2 beats with tlast -> output is data0, data1, PAD, PAD, with tlast on the 4th beat; s_tready=0 for 2 cycles; stat_short_lines=1.
REQ-029 Width 4, input line of 6 beats -> 4 beats are output with tlast on the 4th; 2 beats are dropped; stat_long_lines=1.
REQ-030 Early tuser at (2,1) -> a new frame starts at that beat with output tuser=1; stat_early_sof=1; no pad beats.
REQ-031 Random m_tready at 30% low over 3 frames of 16x4 -> no data loss or duplication; output held stable while stalled.
REQ-032 aresetn low for 1 cycle mid-line -> all outputs are 0 next cycle; beats before the next tuser are discarded.
